fetch_hazard_ctrl: RTL and testbench
====================================

# fetch_hazard_ctrl

Fetch sequencer and interlock controller that drives the instruction memory address and issues instructions to the decode stage, one per cycle. It decodes each fetched word, tracks destinations of recently issued instructions in a small scoreboard, and inserts bubbles automatically on read-after-write hazards. Programs therefore no longer need hand-placed bubble instructions.

## Interface
- HAZ_DEPTH, 3: number of issue slots a destination register stays pending (1..4).
- BUBBLE, 32'h08E7_0500: bubble word (load into scratch R7), shared from the package.
- CLK_SYS  in  1  system clock, all logic on posedge.
- RST_SYS_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE.
- start_addr  in  10  first instruction address, latched on start.
- end_addr  in  10  last instruction address, latched on start.
- pc  out  10  address to instruction memory (memory registers its output, 1-cycle read latency).
- instruction  in  32  memory read data (word for the pc sampled at the previous edge).
- issue_instr  out  32  instruction to decode; BUBBLE when not valid.
- issue_valid  out  1  issue_instr is a real program instruction.
- busy  out  1  state is PRIME or RUN.
- done  out  1  high in DONE until the next accepted start.
- stall_cnt  out  16  bubbles inserted since last start, saturating at 16'hFFFF.

## Operation
- Decode of candidate word c:
  - op = c[31:26].
  - op 6'b000001 (ALU): sources c[25:21], c[20:16]; dest c[15:11].
  - op 6'b000010 (LOAD): no source; dest c[20:16].
  - op 6'b000011 (STORE): source c[20:16]; no dest.
  - Other opcodes: no source, no dest.
  - Register 7 is scratch: never tracked as dest and never matches as source.
- Scoreboard: HAZ_DEPTH entries of {vld, reg[4:0]}, shifted every RUN cycle.
  - Shift-in is the issued instruction's dest, or vld=0 for a bubble or an instruction without dest.
  - Hazard when any vld entry's reg equals any source of the candidate.
- Candidate selection: hold register if occupied, else `instruction`.
- FSM:
  - IDLE: start latches addresses, clears stall_cnt, sets pc=start_addr, then PRIME.
  - PRIME: one cycle; pc advances to start_addr+1; then RUN.
  - RUN, no hazard: issue the candidate, clear hold, advance pc.
  - RUN, hazard: issue BUBBLE (issue_valid=0), increment stall_cnt, freeze pc. If the candidate came from `instruction`, load it into hold.
  - Issuing the instruction whose address equals end_addr: go to DONE and stop advancing pc.
  - DONE: start behaves as in IDLE.
- pc increments modulo 1024 (1023 -> 0). end_addr below start_addr is legal and runs through the wrap.
- Start outside IDLE/DONE is ignored.

## Timing
- Reset values:
  - pc = 0, issue_instr = BUBBLE, issue_valid = 0, busy = 0, done = 0, stall_cnt = 0.
  - Scoreboard all invalid, hold empty, state IDLE.
- issue_instr and issue_valid are registered: a decision made in cycle c appears in cycle c+1.
- start sampled at edge 0 -> PRIME in cycle 1 -> word mem[start_addr] on `instruction` in cycle 2 -> first issue_valid in cycle 3.
- Stall protocol:
  - mem[A] hazards in cycle t: hold = mem[A] and pc stays at A+1.
  - The bus carries mem[A+1] from t+1 onward.
  - Hold issues in cycle t+k and pc advances to A+2 in that cycle.
  - mem[A+1] is the candidate in cycle t+k+1, with no extra bubble.
- Maximum consecutive bubbles for one instruction = HAZ_DEPTH.
- Reset asserted mid-run returns every register to its reset value immediately. An in-flight hold is discarded.

## Structure
- Package fetch_pkg holds:
  - Opcode constants OP_ALU, OP_LOAD, OP_STORE.
  - BUBBLE, SCRATCH_REG = 5'd7.
  - State enum {IDLE, PRIME, RUN, DONE}.
  - Field-extract functions.
- One sub-module: hazard_scoreboard. It holds the shift register and compare and outputs a hazard flag, given two source regs with enables, a dest with enable, and a shift strobe.

## Test plan
- Independent stream: words 0..3 are ALU ops using disjoint registers, start_addr=0, end_addr=3.
  - Required: issue_valid high in cycles 3..6 with the words in order.
  - Then done=1 and stall_cnt=0.
- Back-to-back RAW: LOAD R0 at 0, ALU R4=R0*R1 at 1, HAZ_DEPTH=3.
  - Required: exactly 3 bubbles between the two issues and stall_cnt=3.
  - pc holds at 2 during the stall.
- Bubble-padded program: the same RAW pair separated by three explicit BUBBLE words.
  - Required: stall_cnt=0.
- R7 exemption: LOAD R7 followed by STORE R7.
  - Required: no stall.
- Wrap: start_addr=1022, end_addr=1.
  - Required: pc sequence 1022,1023,0,1,2, then done after issuing address 1.
- Reset mid-stall: assert RST_SYS_N=0 during the 2nd bubble.
  - Required: the next cycle shows reset values.
  - A restart then issues from start_addr with an empty scoreboard.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: opcodes, the bubble word,
// the controller state type and instruction field decode helpers.
package fetch_pkg;

  localparam logic [5:0]  OP_ALU      = 6'b000001;
  localparam logic [5:0]  OP_LOAD     = 6'b000010;
  localparam logic [5:0]  OP_STORE    = 6'b000011;

  // Bubble is "load into scratch R7", harmless to the register file.
  localparam logic [31:0] BUBBLE      = 32'h08E7_0500;
  localparam logic [4:0]  SCRATCH_REG = 5'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Register usage of one instruction word; disabled fields are don't-care.
  typedef struct packed {
    logic       src1_en;
    logic [4:0] src1;
    logic       src2_en;
    logic [4:0] src2;
    logic       dest_en;
    logic [4:0] dest;
  } decode_t;

  function automatic logic [5:0] get_op(input logic [31:0] w);
    return 6'(w >> 26);
  endfunction

  function automatic logic [4:0] get_rs(input logic [31:0] w);
    return 5'(w >> 21);
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] w);
    return 5'(w >> 16);
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] w);
    return 5'(w >> 11);
  endfunction

  // Scratch register R7 never creates or consumes a dependency.
  function automatic decode_t decode_word(input logic [31:0] w);
    decode_t d;
    d = '0;
    case (get_op(w))
      OP_ALU: begin
        d.src1_en = 1'b1;
        d.src1    = get_rs(w);
        d.src2_en = 1'b1;
        d.src2    = get_rt(w);
        d.dest_en = 1'b1;
        d.dest    = get_rd(w);
      end
      OP_LOAD: begin
        d.dest_en = 1'b1;
        d.dest    = get_rt(w);
      end
      OP_STORE: begin
        d.src1_en = 1'b1;
        d.src1    = get_rt(w);
      end
      default: begin
      end
    endcase
    if (d.src1 == SCRATCH_REG) d.src1_en = 1'b0;
    if (d.src2 == SCRATCH_REG) d.src2_en = 1'b0;
    if (d.dest == SCRATCH_REG) d.dest_en = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of destinations of the last DEPTH issue slots, compared
// against the sources of the current candidate to flag read-after-write.
module hazard_scoreboard
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       CLK_SYS,
  input  logic       RST_SYS_N,
  input  logic       shift_en,
  input  logic       dest_en,
  input  logic [4:0] dest,
  input  logic       src1_en,
  input  logic [4:0] src1,
  input  logic       src2_en,
  input  logic [4:0] src2,
  output logic       hazard
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DEPTH-1:0][4:0] reg_q, reg_d;

  // Next scoreboard contents: newest slot enters at index 0, oldest falls off.
  always_comb begin
    vld_d = vld_q;
    reg_d = reg_q;
    if (shift_en) begin
      vld_d[0] = dest_en && (dest != SCRATCH_REG);
      reg_d[0] = dest;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        reg_d[i] = reg_q[i-1];
      end
    end
  end

  // Any pending destination matching any live source stalls the candidate.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ((src1_en && (reg_q[i] == src1)) ||
                       (src2_en && (reg_q[i] == src2)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Scoreboard storage.
  always_ff @(posedge CLK_SYS or negedge RST_SYS_N) begin
    if (!RST_SYS_N) begin
      vld_q <= '0;
      reg_q <= '0;
    end else begin
      vld_q <= vld_d;
      reg_q <= reg_d;
    end
  end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch sequencer: walks pc from start_addr to end_addr, issues one word per
// cycle to decode and inserts bubbles while the scoreboard reports a hazard.
module fetch_hazard_ctrl
  import fetch_pkg::*;
#(
  parameter int HAZ_DEPTH = 3
) (
  input  logic        CLK_SYS,
  input  logic        RST_SYS_N,
  input  logic        start,
  input  logic [9:0]  start_addr,
  input  logic [9:0]  end_addr,
  output logic [9:0]  pc,
  input  logic [31:0] instruction,
  output logic [31:0] issue_instr,
  output logic        issue_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cnt
);

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [9:0]  end_q, end_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] issue_instr_q, issue_instr_d;
  logic        issue_valid_q, issue_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] cand;
  decode_t     cand_dec;
  logic [9:0]  cand_addr;
  logic        hazard;
  logic        sb_shift;
  logic        sb_dest_en;

  // A stalled word waits in hold; otherwise the memory bus is the candidate.
  // pc always sits one past the candidate's address while running.
  always_comb begin
    cand      = hold_vld_q ? hold_q : instruction;
    cand_dec  = decode_word(cand);
    cand_addr = pc_q - 10'd1;
  end

  hazard_scoreboard #(
    .DEPTH(HAZ_DEPTH)
  ) u_scoreboard (
    .CLK_SYS  (CLK_SYS),
    .RST_SYS_N(RST_SYS_N),
    .shift_en (sb_shift),
    .dest_en  (sb_dest_en),
    .dest     (cand_dec.dest),
    .src1_en  (cand_dec.src1_en),
    .src1     (cand_dec.src1),
    .src2_en  (cand_dec.src2_en),
    .src2     (cand_dec.src2),
    .hazard   (hazard)
  );

  // Controller next-state: start handling, priming and issue/stall decisions.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    end_d         = end_q;
    hold_vld_d    = hold_vld_q;
    hold_d        = hold_q;
    issue_instr_d = BUBBLE;
    issue_valid_d = 1'b0;
    stall_cnt_d   = stall_cnt_q;
    sb_shift      = 1'b0;
    sb_dest_en    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          end_d       = end_addr;
          stall_cnt_d = '0;
          pc_d        = start_addr;
          state_d     = PRIME;
        end
      end
      PRIME: begin
        pc_d    = pc_q + 10'd1;
        state_d = RUN;
      end
      RUN: begin
        sb_shift = 1'b1;
        if (hazard) begin
          if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
          if (!hold_vld_q) begin
            hold_vld_d = 1'b1;
            hold_d     = instruction;
          end
        end else begin
          issue_instr_d = cand;
          issue_valid_d = 1'b1;
          hold_vld_d    = 1'b0;
          sb_dest_en    = cand_dec.dest_en;
          if (cand_addr == end_q) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset discards any in-flight hold.
  always_ff @(posedge CLK_SYS or negedge RST_SYS_N) begin
    if (!RST_SYS_N) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      end_q         <= '0;
      hold_vld_q    <= 1'b0;
      hold_q        <= '0;
      issue_instr_q <= BUBBLE;
      issue_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      end_q         <= end_d;
      hold_vld_q    <= hold_vld_d;
      hold_q        <= hold_d;
      issue_instr_q <= issue_instr_d;
      issue_valid_q <= issue_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign issue_instr = issue_instr_q;
  assign issue_valid = issue_valid_q;
  assign busy        = (state_q == PRIME) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed program table, a reset-during-stall
// sequence and random programs checked against a slot-level program model.
module tb_fetch_hazard_ctrl;

  localparam int          HAZ_DEPTH = 3;
  localparam logic [31:0] TB_BUBBLE = 32'h08E7_0500;

  logic        CLK_SYS;
  logic        RST_SYS_N;
  logic        start;
  logic [9:0]  start_addr;
  logic [9:0]  end_addr;
  logic [9:0]  pc;
  logic [31:0] instruction;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic [9:0]        startAddr;
    logic [9:0]        endAddr;
    logic [3:0]        numWords;
    logic [7:0][31:0]  words;
    logic [15:0]       expStalls;
    logic [7:0]        expIssues;
  } vec_t;

  vec_t vecs [7];

  int checkCount = 0;
  int passCount  = 0;
  int sbQ [$];

  fetch_hazard_ctrl #(
    .HAZ_DEPTH(HAZ_DEPTH)
  ) dut (
    .CLK_SYS    (CLK_SYS),
    .RST_SYS_N  (RST_SYS_N),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .pc         (pc),
    .instruction(instruction),
    .issue_instr(issue_instr),
    .issue_valid(issue_valid),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  // Free-running clock.
  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;

  // Instruction memory with one cycle of read latency.
  always @(posedge CLK_SYS) instruction <= mem[pc];

  // Absolute bound on simulated time.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] makeAlu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {6'b000001, s1, s2, d, 11'd0};
  endfunction

  function automatic logic [31:0] makeLoad(input logic [4:0] d);
    return {6'b000010, 5'd0, d, 16'd0};
  endfunction

  function automatic logic [31:0] makeStore(input logic [4:0] s);
    return {6'b000011, 5'd0, s, 16'd0};
  endfunction

  // Register usage of a word as plain integers; -1 means none.
  function automatic void modelDecode(input logic [31:0] w, output int s1, output int s2, output int d);
    int op;
    op = int'(w >> 26);
    s1 = -1; s2 = -1; d = -1;
    if (op == 1) begin
      s1 = int'((w >> 21) & 32'h1F);
      s2 = int'((w >> 16) & 32'h1F);
      d  = int'((w >> 11) & 32'h1F);
    end else if (op == 2) begin
      d  = int'((w >> 16) & 32'h1F);
    end else if (op == 3) begin
      s1 = int'((w >> 16) & 32'h1F);
    end
    if (s1 == 7) s1 = -1;
    if (s2 == 7) s2 = -1;
    if (d == 7) d = -1;
  endfunction

  function automatic void modelReset();
    sbQ.delete();
    for (int i = 0; i < HAZ_DEPTH; i++) sbQ.push_back(-1);
  endfunction

  function automatic bit modelHazard(input int s1, input int s2);
    foreach (sbQ[i]) begin
      if (sbQ[i] >= 0 && (sbQ[i] == s1 || sbQ[i] == s2)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void modelShift(input int d);
    sbQ.push_front(d);
    sbQ.delete(sbQ.size() - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // One-cycle start pulse; returns at the negedge of the PRIME cycle.
  task automatic applyStimulus(input int sa, input int ea);
    @(negedge CLK_SYS);
    start      = 1'b1;
    start_addr = 10'(sa);
    end_addr   = 10'(ea);
    @(negedge CLK_SYS);
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ":pc"},          32'(pc),          32'd0);
    checkOutput({tag, ":issue_instr"}, issue_instr,      TB_BUBBLE);
    checkOutput({tag, ":issue_valid"}, 32'(issue_valid), 32'd0);
    checkOutput({tag, ":busy"},        32'(busy),        32'd0);
    checkOutput({tag, ":done"},        32'(done),        32'd0);
    checkOutput({tag, ":stall_cnt"},   32'(stall_cnt),   32'd0);
  endtask

  task automatic applyReset();
    @(negedge CLK_SYS);
    RST_SYS_N = 1'b0;
    @(negedge CLK_SYS);
    RST_SYS_N = 1'b1;
    modelReset();
  endtask

  // Runs one program cycle by cycle against the slot model.  The model only
  // knows "next address to issue" and the dests of the last HAZ_DEPTH slots.
  task automatic runProgram(input int sa, input int ea, input bit poke, input string tag, output int dutIssues);
    int nextAddr;
    int stalls;
    int cycles;
    bit finished;
    bit expValid;
    logic [31:0] expInstr;
    logic [31:0] w;
    int s1, s2, d;
    nextAddr = sa; stalls = 0; cycles = 0; finished = 1'b0;
    expValid = 1'b0; expInstr = TB_BUBBLE; dutIssues = 0;
    applyStimulus(sa, ea);
    checkOutput({tag, ":prime_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, ":prime_pc"},   32'(pc),   32'(sa));
    @(negedge CLK_SYS);
    while (!finished && cycles < 400) begin
      checkOutput({tag, ":issue_valid"}, 32'(issue_valid), 32'(expValid));
      checkOutput({tag, ":issue_instr"}, issue_instr,      expInstr);
      checkOutput({tag, ":pc"},          32'(pc),          32'((nextAddr + 1) % 1024));
      if (issue_valid) dutIssues++;
      w = mem[nextAddr];
      modelDecode(w, s1, s2, d);
      if (modelHazard(s1, s2)) begin
        expValid = 1'b0;
        expInstr = TB_BUBBLE;
        stalls++;
        modelShift(-1);
      end else begin
        expValid = 1'b1;
        expInstr = w;
        modelShift(d);
        if (nextAddr == ea) finished = 1'b1;
        else nextAddr = (nextAddr + 1) % 1024;
      end
      if (poke && cycles == 2) begin
        start      = 1'b1;
        start_addr = 10'($urandom_range(0, 1023));
        end_addr   = 10'($urandom_range(0, 1023));
      end
      @(negedge CLK_SYS);
      start = 1'b0;
      cycles++;
    end
    if (!finished) begin
      checkCount++;
      $display("[TB] FAIL %s:timeout: got no end of program, expected end within 400 cycles", tag);
    end
    checkOutput({tag, ":last_valid"}, 32'(issue_valid), 32'(expValid));
    checkOutput({tag, ":last_instr"}, issue_instr,      expInstr);
    checkOutput({tag, ":done"},       32'(done),        32'd1);
    checkOutput({tag, ":busy_end"},   32'(busy),        32'd0);
    checkOutput({tag, ":pc_end"},     32'(pc),          32'((ea + 1) % 1024));
    checkOutput({tag, ":stall_cnt"},  32'(stall_cnt),   32'(stalls));
    if (issue_valid) dutIssues++;
    @(negedge CLK_SYS);
    checkOutput({tag, ":idle_valid"}, 32'(issue_valid), 32'd0);
    checkOutput({tag, ":idle_instr"}, issue_instr,      TB_BUBBLE);
    checkOutput({tag, ":done_hold"},  32'(done),        32'd1);
  endtask

  function automatic logic [31:0] randWord();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0, 1:    return makeAlu(a, b, c);
      2:       return makeLoad(a);
      3:       return makeStore(a);
      4:       return {6'b010000, 26'($urandom)};
      default: return TB_BUBBLE;
    endcase
  endfunction

  initial begin
    int issues;
    int sa, len;
    bit seen;
    RST_SYS_N  = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    // Directed programs with hand-derived stall and issue counts.
    for (int k = 0; k < 7; k++) vecs[k] = '0;
    vecs[0].startAddr = 10'd0;    vecs[0].endAddr = 10'd3; vecs[0].numWords = 4'd4;
    vecs[0].words[0] = makeAlu(1, 2, 3);    vecs[0].words[1] = makeAlu(4, 5, 6);
    vecs[0].words[2] = makeAlu(8, 9, 10);   vecs[0].words[3] = makeAlu(11, 12, 13);
    vecs[0].expStalls = 16'd0;    vecs[0].expIssues = 8'd4;
    vecs[1].startAddr = 10'd0;    vecs[1].endAddr = 10'd1; vecs[1].numWords = 4'd2;
    vecs[1].words[0] = makeLoad(0);         vecs[1].words[1] = makeAlu(4, 0, 1);
    vecs[1].expStalls = 16'd3;    vecs[1].expIssues = 8'd2;
    vecs[2].startAddr = 10'd0;    vecs[2].endAddr = 10'd4; vecs[2].numWords = 4'd5;
    vecs[2].words[0] = makeLoad(0);         vecs[2].words[1] = TB_BUBBLE;
    vecs[2].words[2] = TB_BUBBLE;           vecs[2].words[3] = TB_BUBBLE;
    vecs[2].words[4] = makeAlu(4, 0, 1);
    vecs[2].expStalls = 16'd0;    vecs[2].expIssues = 8'd5;
    vecs[3].startAddr = 10'd100;  vecs[3].endAddr = 10'd101; vecs[3].numWords = 4'd2;
    vecs[3].words[0] = makeLoad(7);         vecs[3].words[1] = makeStore(7);
    vecs[3].expStalls = 16'd0;    vecs[3].expIssues = 8'd2;
    vecs[4].startAddr = 10'd1022; vecs[4].endAddr = 10'd1; vecs[4].numWords = 4'd4;
    vecs[4].words[0] = makeAlu(1, 2, 3);    vecs[4].words[1] = makeAlu(4, 5, 6);
    vecs[4].words[2] = makeAlu(8, 9, 10);   vecs[4].words[3] = makeAlu(11, 12, 13);
    vecs[4].expStalls = 16'd0;    vecs[4].expIssues = 8'd4;
    vecs[5].startAddr = 10'd200;  vecs[5].endAddr = 10'd202; vecs[5].numWords = 4'd3;
    vecs[5].words[0] = makeLoad(3);         vecs[5].words[1] = makeAlu(9, 10, 11);
    vecs[5].words[2] = makeStore(3);
    vecs[5].expStalls = 16'd2;    vecs[5].expIssues = 8'd3;
    vecs[6].startAddr = 10'd300;  vecs[6].endAddr = 10'd301; vecs[6].numWords = 4'd2;
    vecs[6].words[0] = makeLoad(5);         vecs[6].words[1] = makeAlu(6, 1, 5);
    vecs[6].expStalls = 16'd3;    vecs[6].expIssues = 8'd2;

    @(negedge CLK_SYS);
    @(negedge CLK_SYS);
    checkResetValues("reset");
    RST_SYS_N = 1'b1;
    modelReset();

    for (int k = 0; k < 7; k++) begin
      applyReset();
      for (int i = 0; i < int'(vecs[k].numWords); i++)
        mem[(int'(vecs[k].startAddr) + i) % 1024] = vecs[k].words[i];
      runProgram(int'(vecs[k].startAddr), int'(vecs[k].endAddr), 1'b0, $sformatf("vec%0d", k), issues);
      checkOutput($sformatf("vec%0d:table_stalls", k), 32'(stall_cnt), 32'(vecs[k].expStalls));
      checkOutput($sformatf("vec%0d:table_issues", k), 32'(issues),    32'(vecs[k].expIssues));
    end

    // Reset while the second bubble is on the issue port, then restart.
    applyReset();
    mem[0] = makeLoad(0);
    mem[1] = makeAlu(4, 0, 1);
    applyStimulus(0, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK_SYS);
      if (stall_cnt == 16'd2) seen = 1'b1;
    end
    checkOutput("rst_stall:second_bubble_seen", 32'(seen), 32'd1);
    checkOutput("rst_stall:bubble_valid", 32'(issue_valid), 32'd0);
    RST_SYS_N = 1'b0;
    @(negedge CLK_SYS);
    checkResetValues("rst_stall");
    RST_SYS_N = 1'b1;
    modelReset();
    runProgram(0, 1, 1'b0, "rst_restart", issues);
    checkOutput("rst_restart:stalls", 32'(stall_cnt), 32'd3);
    checkOutput("rst_restart:issues", 32'(issues),    32'd2);

    // Random programs run back to back; scoreboard state carries over.
    for (int p = 0; p < 40; p++) begin
      sa  = int'($urandom_range(0, 1023));
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) mem[(sa + i) % 1024] = randWord();
      runProgram(sa, (sa + len - 1) % 1024, 1'($urandom_range(0, 1)), $sformatf("rand%0d", p), issues);
      checkOutput($sformatf("rand%0d:issues", p), 32'(issues), 32'(len));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
